// File: rtl/ysyx_22040237_ifu_fetch_ctrl.sv
// Instruction fetch control: owns the fetch PC, keeps one imem request outstanding,
// buffers the returned word and presents it to decode. Redirects from execute
// retarget the PC and cancel any fetch already in flight.
module ysyx_22040237_ifu_fetch_ctrl #(
   parameter int unsigned         ADDR_W   = 32,
   parameter int unsigned         INST_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   input  logic              imem_resp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_fault,
   output logic              misalign
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_addr_q;
   logic              drop_q, drop_d;
   logic              capture;
   logic [ADDR_W-1:0] redirect_tgt;
   logic [INST_W-1:0] buf_data_q;
   logic              buf_err_q;
   logic [ADDR_W-1:0] buf_pc_q;
   logic              misalign_q;

   // Redirect targets are forced word aligned; the low bits only raise misalign.
   assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Next-state, next-PC and drop-flag logic for the fetch FSM.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      capture = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redirect_tgt;
         end
         ST_REQ: begin
            // The pending address must stay stable, so a redirect here only
            // retargets pc and marks the request that will be accepted as stale.
            if (redirect_valid) begin
               pc_d   = redirect_tgt;
               drop_d = 1'b1;
            end
            if (imem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid) pc_d = redirect_tgt;
            if (imem_resp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         ST_HOLD: begin
            // Redirect wins over sequential advance; a coincident inst_ready still consumes.
            if (redirect_valid) begin
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + ADDR_W'(4);
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, PC, drop flag, request address and misalign pulse registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         req_addr_q <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         // Address follows pc until a request is presented, then holds until accepted.
         if (state_q != ST_REQ) req_addr_q <= pc_d;
         misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

   // Instruction buffer loaded when a live response arrives.
   always_ff @(posedge clk) begin
      // NOTE: the buffer is reset because it drives outputs that must read zero out of reset.
      if (rst) begin
         buf_data_q <= '0;
         buf_err_q  <= 1'b0;
         buf_pc_q   <= '0;
      end else if (capture) begin
         buf_data_q <= imem_resp_data;
         buf_err_q  <= imem_resp_err;
         buf_pc_q   <= pc_q;
      end
   end

   assign imem_req_valid = (state_q == ST_REQ);
   assign imem_req_addr  = req_addr_q;
   assign inst_valid     = (state_q == ST_HOLD);
   assign inst_o         = buf_data_q;
   assign inst_pc        = buf_pc_q;
   assign inst_fault     = buf_err_q;
   assign misalign       = misalign_q;

endmodule

// File: tb/tb_ysyx_22040237_ifu_fetch_ctrl.sv
// Directed bench for the fetch controller: inputs driven and outputs checked on
// the falling edge, expected values written out by hand per step.
module tb_ysyx_22040237_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        misalign;

   int n_vec = 0;
   int n_err = 0;

   ysyx_22040237_ifu_fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_o          (inst_o),
      .inst_pc         (inst_pc),
      .inst_fault      (inst_fault),
      .misalign        (misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Wait (bounded) for a request, check its address, and let it be accepted.
   task automatic expect_req(input string tag, input logic [31:0] addr);
      int n = 0;
      while (!imem_req_valid && n < 8) begin
         step();
         n++;
      end
      check({tag, "_reqv"}, 32'(imem_req_valid), 32'd1);
      check({tag, "_addr"}, imem_req_addr, addr);
      imem_req_ready = 1'b1;
      step();
   endtask

   task automatic respond(input logic [31:0] data, input logic err);
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      imem_resp_err   = err;
      step();
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
   endtask

   task automatic expect_inst(input string tag, input logic [31:0] data,
                              input logic [31:0] pc, input logic fault);
      check({tag, "_ival"},  32'(inst_valid), 32'd1);
      check({tag, "_inst"},  inst_o, data);
      check({tag, "_pc"},    inst_pc, pc);
      check({tag, "_fault"}, 32'(inst_fault), 32'(fault));
   endtask

   task automatic consume();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt, input logic with_ready);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      inst_ready     = with_ready;
      step();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
      inst_ready      = 1'b0;
      step();
      step();
      // Reset state
      check("rst_reqv",  32'(imem_req_valid), 32'd0);
      check("rst_addr",  imem_req_addr, 32'h8000_0000);
      check("rst_ival",  32'(inst_valid), 32'd0);
      check("rst_inst",  inst_o, 32'd0);
      check("rst_pc",    inst_pc, 32'd0);
      check("rst_fault", 32'(inst_fault), 32'd0);
      check("rst_mis",   32'(misalign), 32'd0);
      rst = 1'b0;
      check("idle_reqv", 32'(imem_req_valid), 32'd0);
      step();
      check("first_reqv", 32'(imem_req_valid), 32'd1);

      // Sequential fetch, including a bus error on the second word
      expect_req("f0", 32'h8000_0000);
      check("wait_reqv", 32'(imem_req_valid), 32'd0);
      check("wait_ival", 32'(inst_valid), 32'd0);
      respond(32'h1111_0001, 1'b0);
      expect_inst("f0", 32'h1111_0001, 32'h8000_0000, 1'b0);
      consume();
      expect_req("f1", 32'h8000_0004);
      respond(32'h2222_0002, 1'b1);
      expect_inst("f1", 32'h2222_0002, 32'h8000_0004, 1'b1);
      consume();
      expect_req("f2", 32'h8000_0008);
      respond(32'h3333_0003, 1'b0);
      expect_inst("f2", 32'h3333_0003, 32'h8000_0008, 1'b0);

      // Decode stalls for five cycles: buffer stable, no new request
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_ival", 32'(inst_valid), 32'd1);
         check("stall_inst", inst_o, 32'h3333_0003);
         check("stall_pc",   inst_pc, 32'h8000_0008);
         check("stall_reqv", 32'(imem_req_valid), 32'd0);
      end
      consume();

      // Redirect while waiting: the response in flight is discarded
      expect_req("f3", 32'h8000_000C);
      redirect(32'h8000_0100, 1'b0);
      check("al_mis", 32'(misalign), 32'd0);
      respond(32'hDEAD_0004, 1'b0);
      check("drop_ival", 32'(inst_valid), 32'd0);
      expect_req("rw", 32'h8000_0100);
      respond(32'h4444_0005, 1'b0);
      expect_inst("rw", 32'h4444_0005, 32'h8000_0100, 1'b0);

      // Redirect in HOLD with inst_ready: consumed, fetch goes to target
      redirect(32'h8000_0200, 1'b1);
      check("rh_ival", 32'(inst_valid), 32'd0);
      expect_req("rh", 32'h8000_0200);
      respond(32'h5555_0006, 1'b0);
      expect_inst("rh", 32'h5555_0006, 32'h8000_0200, 1'b0);
      consume();

      // Misaligned redirect in WAIT: one-cycle misalign pulse, aligned refetch
      expect_req("f4", 32'h8000_0204);
      redirect(32'h8000_0102, 1'b0);
      check("mis_hi", 32'(misalign), 32'd1);
      step();
      check("mis_lo", 32'(misalign), 32'd0);
      respond(32'hDEAD_0007, 1'b0);
      check("mis_drop_ival", 32'(inst_valid), 32'd0);
      expect_req("mis", 32'h8000_0100);

      // Reset while waiting; a late response is ignored
      rst = 1'b1;
      step();
      check("rw_reqv", 32'(imem_req_valid), 32'd0);
      check("rw_addr", imem_req_addr, 32'h8000_0000);
      check("rw_ival", 32'(inst_valid), 32'd0);
      rst             = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_0008;
      step();
      imem_resp_valid = 1'b0;
      check("late_ival", 32'(inst_valid), 32'd0);
      expect_req("rr", 32'h8000_0000);
      respond(32'h6666_0009, 1'b0);
      expect_inst("rr", 32'h6666_0009, 32'h8000_0000, 1'b0);
      consume();

      // Redirect while a request is stalled: address stays, accepted fetch is dropped
      imem_req_ready = 1'b0;
      redirect(32'h8000_0300, 1'b0);
      check("rq_reqv", 32'(imem_req_valid), 32'd1);
      check("rq_addr", imem_req_addr, 32'h8000_0004);
      step();
      check("rq_addr2", imem_req_addr, 32'h8000_0004);
      imem_req_ready = 1'b1;
      step();
      respond(32'hDEAD_000A, 1'b0);
      check("rq_ival", 32'(inst_valid), 32'd0);
      expect_req("rq", 32'h8000_0300);
      respond(32'h7777_000B, 1'b0);
      expect_inst("rq", 32'h7777_000B, 32'h8000_0300, 1'b0);

      // PC wraps from the top of the address space
      redirect(32'hFFFF_FFFC, 1'b0);
      expect_req("top", 32'hFFFF_FFFC);
      respond(32'h8888_000C, 1'b0);
      expect_inst("top", 32'h8888_000C, 32'hFFFF_FFFC, 1'b0);
      consume();
      expect_req("wrap", 32'h0000_0000);
      respond(32'h9999_000D, 1'b0);
      expect_inst("wrap", 32'h9999_000D, 32'h0000_0000, 1'b0);
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
